// File: rtl/apb_pkg.sv
// ----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB command master:
//   - apb_state_e : requester FSM states (IDLE, SETUP, ACCESS)
//   - ADDR_W_DEF / DATA_W_DEF : default bus widths
//   - ALIGN_MASK  : low address bits that must be zero for a word access
//   - is_aligned(): helper applying ALIGN_MASK to the two low address bits
// ----------------------------------------------------------------------------
package apb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // The slave is a bank of 32-bit registers, so only word addresses are legal.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    function automatic logic is_aligned(input logic [1:0] low_bits);
        return (low_bits & ALIGN_MASK) == 2'b00;
    endfunction

endpackage : apb_pkg

// File: rtl/apb_wait_timer.sv
// ----------------------------------------------------------------------------
// apb_wait_timer
// Counts ACCESS cycles spent waiting for PREADY and flags when the wait
// budget is used up.
//   clk     in   clock
//   rst_n   in   synchronous active-low reset (count -> 0)
//   clear   in   synchronous clear, has priority over enable
//   enable  in   increment the count this cycle
//   expire  out  count has reached TIMEOUT_CYCLES-1 (never when TIMEOUT_CYCLES=0)
// ----------------------------------------------------------------------------
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TMR_W          = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam bit TMR_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TMR_W-1:0] LIMIT =
        (TIMEOUT_CYCLES == 0) ? '0 : TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] count;

    // Saturate rather than wrap so a disabled timeout can never alias back
    // onto the limit after a very long wait.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = TMR_EN && (count == LIMIT);

endmodule : apb_wait_timer

// File: rtl/apb_cmd_master.sv
// ----------------------------------------------------------------------------
// apb_cmd_master
// APB3 requester: turns a valid/ready command stream into SETUP/ACCESS bus
// transfers and returns exactly one response pulse per accepted command.
//
// Handshake semantics: a command transfers on the PCLK rising edge where
// cmd_valid && cmd_ready. cmd_ready is high only in IDLE and only while
// rsp_valid is low. rsp_valid is a single-cycle pulse with no backpressure;
// rsp_rdata/rsp_error hold their value until the next response.
//
// Ports
//   PCLK, PRESETn         clock, synchronous active-low reset
//   cmd_valid/ready       command handshake
//   cmd_write/addr/wdata  command payload (byte address)
//   rsp_valid             response pulse
//   rsp_rdata             read data, 0 for writes and errors
//   rsp_error             PSLVERR, wait timeout or misaligned address
//   PSEL..PWDATA          APB requester outputs (all registered)
//   PRDATA/PREADY/PSLVERR APB completer inputs
//   fsm_state             debug view of the FSM state
// ----------------------------------------------------------------------------
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TMR_W          = 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,

    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,

    output apb_state_e        fsm_state
);

    apb_state_e state;
    logic       tmr_expire;
    logic       accept;

    // Gating on rsp_valid guarantees at least one idle cycle between a
    // response and the next accept.
    assign cmd_ready = (state == IDLE) && !rsp_valid;
    assign accept    = cmd_valid && cmd_ready;
    assign fsm_state = state;

    // Timer restarts in SETUP so every ACCESS phase starts counting from 0.
    apb_wait_timer #(
        .TMR_W          (TMR_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk    (PCLK),
        .rst_n  (PRESETn),
        .clear  (state == SETUP),
        .enable ((state == ACCESS) && !PREADY),
        .expire (tmr_expire)
    );

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state     <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else begin
            // Response is a pulse: cleared every cycle unless re-raised below.
            rsp_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_aligned(cmd_addr[1:0])) begin
                            PWRITE  <= cmd_write;
                            PADDR   <= cmd_addr;
                            PWDATA  <= cmd_wdata;
                            PSEL    <= 1'b1;
                            PENABLE <= 1'b0;
                            state   <= SETUP;
                        end else begin
                            // Misaligned: answer locally, bus untouched.
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end

                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end

                ACCESS: begin
                    // PREADY wins over a timeout firing in the same cycle.
                    if (PREADY) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state     <= IDLE;
                        rsp_valid <= 1'b1;
                        rsp_error <= PSLVERR;
                        rsp_rdata <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
                    end else if (tmr_expire) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state     <= IDLE;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b1;
                        rsp_rdata <= '0;
                    end
                end

                default: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule : apb_cmd_master

// File: tb/tb_apb_cmd_master.sv
// ----------------------------------------------------------------------------
// tb_apb_cmd_master
// Drives apb_cmd_master against a 16-register APB completer model with
// configurable wait states, stuck-low PREADY and PSLVERR injection.
// ----------------------------------------------------------------------------
module tb_apb_cmd_master;
    import apb_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              PCLK = 1'b0;
    logic              PRESETn = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_error;
    logic              PSEL, PENABLE, PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY, PSLVERR;
    apb_state_e        fsm_state;

    // ---------------- clock ----------------
    always #5 PCLK = ~PCLK;

    apb_cmd_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(16), .TMR_W(8)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .fsm_state(fsm_state)
    );

    // ---------------- completer model ----------------
    logic [DATA_W-1:0] mem [16] = '{default: '0};
    int  wait_cfg = 0;
    bit  stuck_low = 1'b0;
    bit  slverr_cfg = 1'b0;
    int  acc_cnt = 0;

    always @(posedge PCLK) begin
        if (PSEL && !PENABLE) acc_cnt <= 0;
        else if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    end

    assign PREADY  = PSEL && PENABLE && !stuck_low && (acc_cnt >= wait_cfg);
    assign PSLVERR = PREADY && slverr_cfg;
    assign PRDATA  = mem[PADDR[5:2]];

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && PREADY && PWRITE && !slverr_cfg)
            mem[PADDR[5:2]] <= PWDATA;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic              err;
        logic [DATA_W-1:0] rdata;
        int                lat;
        int                acc_cyc;
    } exp_t;

    typedef struct {
        bit                wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                waits;
        bit                stuck;
        bit                slverr;
        logic              exp_err;
        logic [DATA_W-1:0] exp_rdata;
        int                exp_lat;
        int                exp_psel;
        int                exp_pen;
    } vec_t;

    exp_t              exp_q[$];
    vec_t              vecs[13];
    logic [DATA_W-1:0] shadow[16] = '{default: '0};

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rsp_count = 0;
    int last_rsp_cyc = 0;
    int psel_total = 0, pen_total = 0, pwrite_hi_total = 0, paddr_wrong_total = 0;
    logic [ADDR_W-1:0] exp_paddr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h @%0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and observe the DUT there.
    task automatic tick();
        exp_t e;
        @(negedge PCLK);
        cyc++;
        if (PSEL) begin
            psel_total++;
            if (PWRITE) pwrite_hi_total++;
            if (PADDR !== exp_paddr) paddr_wrong_total++;
        end
        if (PENABLE) begin
            pen_total++;
            chk("penable_implies_psel", 32'(PSEL), 32'd1);
        end
        if (rsp_valid) begin
            rsp_count++;
            last_rsp_cyc = cyc;
            chk("cmd_ready_low_during_rsp", 32'(cmd_ready), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_error", 32'(rsp_error), 32'(e.err));
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_latency", 32'(cyc - e.acc_cyc + 1), 32'(e.lat));
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_cmd(input vec_t v, input bit chk_gap, input string name);
        int n;
        int start_rsp, p0, e0, w0, a0, acc_cyc;
        bit aligned;
        aligned    = (v.addr[1:0] == 2'b00);
        wait_cfg   = v.waits;
        stuck_low  = v.stuck;
        slverr_cfg = v.slverr;
        if (aligned) exp_paddr = v.addr;
        p0 = psel_total; e0 = pen_total; w0 = pwrite_hi_total; a0 = paddr_wrong_total;
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (!cmd_ready) begin
            chk({name, "_accept_timeout"}, 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        acc_cyc = cyc + 1;
        if (chk_gap) chk({name, "_accept_gap"}, 32'(acc_cyc - last_rsp_cyc), 32'd2);
        exp_q.push_back('{err: v.exp_err, rdata: v.exp_rdata, lat: v.exp_lat, acc_cyc: acc_cyc});
        start_rsp = rsp_count;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (rsp_count == start_rsp && n < 60) begin
            tick();
            n++;
        end
        chk({name, "_rsp_seen"}, 32'(rsp_count - start_rsp), 32'd1);
        chk({name, "_psel_cycles"}, 32'(psel_total - p0), 32'(v.exp_psel));
        chk({name, "_penable_cycles"}, 32'(pen_total - e0), 32'(v.exp_pen));
        chk({name, "_pwrite_cycles"}, 32'(pwrite_hi_total - w0),
            v.wr ? 32'(psel_total - p0) : 32'd0);
        chk({name, "_paddr_stable"}, 32'(paddr_wrong_total - a0), 32'd0);
        if (v.wr && aligned && !v.slverr && !v.stuck) shadow[v.addr[5:2]] = v.wdata;
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t r;
        //          wr    addr     wdata        waits stk  err  eerr  erdata       lat psel pen
        vecs[0]  = '{1'b1, 32'h04, 32'h1000_0000, 0,  1'b0, 1'b0, 1'b0, 32'h0,         3,  2,  1};
        vecs[1]  = '{1'b0, 32'h04, 32'h0,         0,  1'b0, 1'b0, 1'b0, 32'h1000_0000, 3,  2,  1};
        vecs[2]  = '{1'b1, 32'h3C, 32'hA5A5_5A5A, 0,  1'b0, 1'b0, 1'b0, 32'h0,         3,  2,  1};
        vecs[3]  = '{1'b0, 32'h3C, 32'h0,         3,  1'b0, 1'b0, 1'b0, 32'hA5A5_5A5A, 6,  5,  4};
        vecs[4]  = '{1'b0, 32'h3C, 32'h0,         0,  1'b1, 1'b0, 1'b1, 32'h0,        18, 17, 16};
        vecs[5]  = '{1'b1, 32'h20, 32'hDEAD_BEEF, 1,  1'b0, 1'b0, 1'b0, 32'h0,         4,  3,  2};
        vecs[6]  = '{1'b0, 32'h20, 32'h0,        15,  1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF,18, 17, 16};
        vecs[7]  = '{1'b1, 32'h02, 32'h1111_1111, 0,  1'b0, 1'b0, 1'b1, 32'h0,         1,  0,  0};
        vecs[8]  = '{1'b1, 32'h08, 32'h2222_2222, 0,  1'b0, 1'b1, 1'b1, 32'h0,         3,  2,  1};
        vecs[9]  = '{1'b0, 32'h08, 32'h0,         0,  1'b0, 1'b1, 1'b1, 32'h0,         3,  2,  1};
        vecs[10] = '{1'b0, 32'h08, 32'h0,         0,  1'b0, 1'b0, 1'b0, 32'h0,         3,  2,  1};
        vecs[11] = '{1'b0, 32'h01, 32'h0,         0,  1'b0, 1'b0, 1'b1, 32'h0,         1,  0,  0};
        vecs[12] = '{1'b1, 32'h00, 32'h1234_5678, 2,  1'b0, 1'b0, 1'b0, 32'h0,         5,  4,  3};

        // Reset state
        repeat (3) tick();
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_pwrite", 32'(PWRITE), 32'd0);
        chk("rst_paddr", PADDR, 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_error", 32'(rsp_error), 32'd0);
        chk("rst_state", 32'(fsm_state), 32'(IDLE));
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        PRESETn = 1'b1;
        tick();

        // Table vectors, issued back to back
        for (int i = 0; i < 13; i++)
            run_cmd(vecs[i], (i != 0), $sformatf("vec%0d", i));

        // Random aligned traffic against the shadow register file
        for (int i = 0; i < 10; i++) begin
            r.wr        = 1'($urandom_range(0, 1));
            r.addr      = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            r.wdata     = $urandom;
            r.waits     = $urandom_range(0, 3);
            r.stuck     = 1'b0;
            r.slverr    = 1'b0;
            r.exp_err   = 1'b0;
            r.exp_rdata = r.wr ? 32'h0 : shadow[r.addr[5:2]];
            r.exp_lat   = 3 + r.waits;
            r.exp_psel  = 2 + r.waits;
            r.exp_pen   = 1 + r.waits;
            run_cmd(r, 1'b1, $sformatf("rnd%0d", i));
        end

        // Reset during ACCESS: abort with no response
        stuck_low  = 1'b1;
        slverr_cfg = 1'b0;
        exp_paddr  = 32'h10;
        cmd_valid  = 1'b1;
        cmd_write  = 1'b0;
        cmd_addr   = 32'h10;
        for (int n = 0; n < 5 && !cmd_ready; n++) tick();
        chk("abort_accept", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("abort_setup_state", 32'(fsm_state), 32'(SETUP));
        tick();
        chk("abort_access_penable", 32'(PENABLE), 32'd1);
        PRESETn = 1'b0;
        tick();
        chk("abort_psel", 32'(PSEL), 32'd0);
        chk("abort_penable", 32'(PENABLE), 32'd0);
        chk("abort_pwrite", 32'(PWRITE), 32'd0);
        chk("abort_paddr", PADDR, 32'd0);
        chk("abort_pwdata", PWDATA, 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_rsp_rdata", rsp_rdata, 32'd0);
        chk("abort_state", 32'(fsm_state), 32'(IDLE));
        PRESETn   = 1'b1;
        stuck_low = 1'b0;
        repeat (3) tick();
        r = '{1'b0, 32'h00, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 3, 2, 1};
        run_cmd(r, 1'b0, "post_reset_read");

        repeat (5) tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_apb_cmd_master

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- APB3 requester stage sitting directly upstream of the 16-register APB slave (map 0x00–0x3C); converts a simple valid/ready command stream into legal SETUP/ACCESS bus transfers.
- Returns one response per command: read data plus an error flag covering PSLVERR, timeout and misalignment.
- Replaces hand-toggled PENABLE/PADDR sequencing with protocol-correct transfers, so the slave sees compliant traffic.

Parameters:
- ADDR_W, 32, PADDR / cmd_addr width
- DATA_W, 32, PWDATA / PRDATA width
- TIMEOUT_CYCLES, 16, max ACCESS cycles waiting for PREADY; 0 disables timeout
- TMR_W, 8, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
- PCLK  in  1  bus clock; single clock domain
- PRESETn  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at PCLK rise
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_error  out  1  PSLVERR, timeout or misaligned address
- PSEL  out  1  slave select
- PENABLE  out  1  access phase
- PWRITE  out  1  direction
- PADDR  out  ADDR_W  address
- PWDATA  out  DATA_W  write data
- PRDATA  in  DATA_W  slave read data
- PREADY  in  1  slave ready; wait states allowed
- PSLVERR  in  1  slave error; sampled only with PREADY in ACCESS

Behaviour:
- Reset (PRESETn=0 at PCLK rise): state IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_error all 0; timer 0.
- Reset mid-transfer aborts immediately; no response is issued for the aborted command.
- FSM states: IDLE, SETUP, ACCESS.
- cmd_ready = 1 only in IDLE and only when rsp_valid is 0, so every accept is at least one cycle after the previous response.
- IDLE, accept with cmd_addr[1:0]==0: latch write/addr/wdata into PWRITE/PADDR/PWDATA; next state SETUP.
- IDLE, accept with cmd_addr[1:0]!=0: no bus activity; next cycle rsp_valid=1, rsp_error=1, rsp_rdata=0; stay IDLE.
- SETUP: PSEL=1, PENABLE=0; unconditionally go to ACCESS next cycle; timer cleared.
- ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable for the whole phase.
- ACCESS && PREADY: go IDLE; next cycle rsp_valid=1, rsp_error=PSLVERR, rsp_rdata = (read && !PSLVERR) ? PRDATA : 0.
- ACCESS && !PREADY: timer increments each cycle.
- Timeout: when TIMEOUT_CYCLES!=0 and timer reaches TIMEOUT_CYCLES-1 while !PREADY, go IDLE and drop PSEL/PENABLE; next cycle rsp_valid=1, rsp_error=1, rsp_rdata=0.
- PREADY in the same cycle the timeout would fire counts as a normal completion.
- Latency, zero wait states: accept edge N; SETUP cycle N+1; ACCESS cycle N+2; rsp_valid cycle N+3; earliest next accept at edge N+4.
- Each wait state adds one cycle to that latency.
- After a transfer, PADDR/PWRITE/PWDATA keep their last values; only PSEL/PENABLE return to 0.
- rsp_rdata and rsp_error hold until the next response; they are meaningful only while rsp_valid=1.
- Output protocol invariant: PENABLE=1 never occurs without PSEL=1.

Decomposition:
- Package apb_pkg: state enum {IDLE, SETUP, ACCESS}; ADDR_W/DATA_W defaults; alignment mask constant.
- Sub-module apb_wait_timer: clear/enable counter with TMR_W width and an expire output; instantiated once.

Test Plan:
- Write 0x0000_0004 <- 0x1000_0000, PREADY=1: PSEL high 2 cycles, PENABLE high 1 cycle; rsp_valid 3 cycles after accept; rsp_error=0.
- Read 0x0000_0004 after that write: rsp_rdata=0x1000_0000; rsp_error=0; PWRITE=0 throughout the transfer.
- Read 0x0000_003C with PREADY low for 3 ACCESS cycles: PENABLE high 4 cycles with PADDR stable; rsp_valid 6 cycles after accept.
- PREADY stuck low, TIMEOUT_CYCLES=16: PSEL drops after 16 ACCESS cycles; rsp_error=1, rsp_rdata=0; next command accepted afterwards.
- Write 0x0000_0002: no PSEL assertion; rsp_valid next cycle with rsp_error=1. Separately, PSLVERR=1 with PREADY: rsp_error=1.
- Assert PRESETn=0 during ACCESS: all outputs 0 on the next edge; no rsp_valid; after release, a read of 0x0000_0000 completes normally.
